// File: rtl/int_arb_pkg.sv
// Shared types and constants for the interrupt arbiter.
// Optional overflow trap source is enabled by defining INT_ARB_OVF_TRAP_EN.
package int_arb_pkg;

    // Arbiter sequencing: choose a winner, wait for the FSM to take it, wait for return.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } arb_state_t;

    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
    localparam int          DEF_VEC_STRIDE = 4;

    // Winner-id width: one extra code is reserved so id NSRC can name the trap.
    function automatic int calc_id_w(input int nsrc);
        return (nsrc < 1) ? 1 : $clog2(nsrc + 1);
    endfunction

endpackage

// File: rtl/int_arb_prio_enc.sv
// Fixed-priority encoder: index 0 wins; valid is low when no request is set.
module int_arb_prio_enc
    import int_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   req,
    output logic           valid,
    output logic [IDW-1:0] idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/int_arbiter.sv
// Interrupt arbiter for the multi-cycle CPU control FSM: latches irq rising
// edges, masks them, presents one fixed-priority winner until acknowledged,
// and blocks further interrupts until the service routine returns.
// Define INT_ARB_OVF_TRAP_EN to add the non-maskable ALU overflow trap (port ovf).
module int_arbiter
    import int_arb_pkg::*;
#(
    parameter int          NSRC       = 4,
    parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
    parameter int          VEC_STRIDE = DEF_VEC_STRIDE,
    localparam int         ID_W       = calc_id_w(NSRC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq,
`ifdef INT_ARB_OVF_TRAP_EN
    input  logic            ovf,
`endif
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_din,
    input  logic            int_ack,
    input  logic            int_done,
    output logic            int_req,
    output logic [31:0]     inter_addr,
    output logic [ID_W-1:0] int_id,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] mask,
    output logic            busy
);

    arb_state_t      state;
    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] irq_rise;
    logic [NSRC-1:0] ack_clr;
    logic            ack_take;
    logic            enc_valid;
    logic [ID_W-1:0] enc_idx;
    logic            win_valid;
    logic [ID_W-1:0] win_id;

    function automatic logic [31:0] vec_addr(input logic [ID_W-1:0] id);
        return VEC_BASE + (32'(id) * 32'(VEC_STRIDE));
    endfunction

    assign irq_rise = irq & ~irq_q;
    assign ack_take = (state == REQ) && int_ack;

    // One-hot clear for the irq source being acknowledged (none for the trap id).
    always_comb begin
        ack_clr = '0;
        if (ack_take && (32'(int_id) < 32'(NSRC)))
            ack_clr[int_id[ID_W-1:0]] = 1'b1;
    end

    int_arb_prio_enc #(
        .N   (NSRC),
        .IDW (ID_W)
    ) u_prio_enc (
        .req   (pending & mask),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

`ifdef INT_ARB_OVF_TRAP_EN
    logic ovf_q;
    logic trap_pend;

    // Overflow edge latch; the set term is OR-ed last so a new edge beats a same-cycle ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q     <= 1'b0;
            trap_pend <= 1'b0;
        end else begin
            ovf_q     <= ovf;
            trap_pend <= (trap_pend & ~(ack_take && (32'(int_id) == 32'(NSRC))))
                       | (ovf & ~ovf_q);
        end
    end

    // The trap ignores the mask and outranks every irq source.
    always_comb begin
        win_valid = trap_pend | enc_valid;
        win_id    = trap_pend ? ID_W'(NSRC) : enc_idx;
    end
`else
    // Without the trap the encoder result is the winner as-is.
    always_comb begin
        win_valid = enc_valid;
        win_id    = enc_idx;
    end
`endif

    // Edge detection, pending latch (set wins over clear) and mask register.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q   <= '0;
            pending <= '0;
            mask    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register here update from pre-edge values, like real flops.
            irq_q   <= irq;
            pending <= (pending & ~ack_clr) | irq_rise;
            if (mask_we)
                mask <= mask_din;
        end
    end

    // Control FSM with registered request, winner id, vector address and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            int_req    <= 1'b0;
            busy       <= 1'b0;
            inter_addr <= '0;
            int_id     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        int_id     <= win_id;
                        inter_addr <= vec_addr(win_id);
                        int_req    <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    // Committed request: held until acked; int_done is ignored here.
                    if (int_ack) begin
                        int_req <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (int_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/int_arbiter.md
Name: int_arbiter

Overview:
- Interrupt arbiter and scheduler for the multi-cycle CPU control FSM.
- Latches interrupt requests from several peripheral sources and applies a software-written enable mask.
- Picks one winner by fixed priority and presents its vector address on `inter_addr`, holding it until the control FSM acknowledges (the FSM then pushes PSW/PC and jumps).
- Blocks further interrupts until the FSM signals return (pop); no nesting.

Parameters:
- NSRC, 4: number of external interrupt sources. Index 0 has the highest priority.
- VEC_BASE, 32'h0000_0100: vector address of source 0.
- VEC_STRIDE, 4: address distance between consecutive vectors.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- irq  input  NSRC  interrupt request lines; level inputs, rising edge detected.
- mask_we  input  1  write enable for the mask register.
- mask_din  input  NSRC  new mask value; 1 = source enabled.
- int_ack  input  1  one-cycle pulse from the control FSM: interrupt taken.
- int_done  input  1  one-cycle pulse from the control FSM: service routine returned (pop).
- int_req  output  1  interrupt request to the control FSM.
- inter_addr  output  32  vector address of the current winner.
- int_id  output  ID_W  winner index, where ID_W = clog2(NSRC+1).
- pending  output  NSRC  latched, not-yet-serviced requests.
- mask  output  NSRC  current mask register.
- busy  output  1  1 while an interrupt is in service.

Behaviour:
- Reset values (synchronous): state=IDLE; pending=0; mask=0; irq_q=0; int_req=0; busy=0; inter_addr=0; int_id=0.
- Reset asserted mid-operation aborts everything; pending requests are lost.
- Edge detect:
  - irq_q <= irq every cycle.
  - pending[i] is set when irq[i] & ~irq_q[i].
  - pending[i] is cleared on int_ack when i == int_id.
  - If set and clear hit the same bit in the same cycle, set wins.
- Mask: on mask_we, mask <= mask_din. This takes effect for arbitration from the next cycle.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if (pending & mask) != 0:
    - int_id <= lowest set index.
    - inter_addr <= VEC_BASE + int_id*VEC_STRIDE (32-bit, modulo 2^32).
    - int_req <= 1; go to REQ.
  - REQ: int_req, int_id and inter_addr are held stable, even if mask or pending change. The request is committed, never withdrawn. On int_ack: clear the winner's pending bit, int_req <= 0, busy <= 1, go to SERVICE.
  - SERVICE: no arbitration. On int_done: busy <= 0, go to IDLE. Arbitration resumes in the cycle after that.
- Ignored strobes: int_ack in IDLE or SERVICE; int_done in IDLE or REQ.
- Latency:
  - irq edge sampled at clock k → pending bit set after edge k.
  - int_req high after edge k+1 (2 cycles), provided the source is enabled and state is IDLE.
  - int_ack and int_done both asserted in REQ: only the ack is processed.
- Edges arriving while the same source is already pending collapse into one request.

Optional Feature:
- Macro: INT_ARB_OVF_TRAP_EN.
- Defined:
  - Adds input port `ovf` (1 bit, ALU overflow).
  - A rising edge of `ovf` sets internal trap_pend.
  - trap_pend is non-maskable and has priority above all irq sources.
  - Trap vector: int_id = NSRC, inter_addr = VEC_BASE + NSRC*VEC_STRIDE.
  - trap_pend is cleared on int_ack for that id.
- Undefined: no `ovf` port; int_id never equals NSRC.

Decomposition:
- Package int_arb_pkg:
  - state enum (IDLE, REQ, SERVICE).
  - ID_W computation function.
  - default VEC_BASE and VEC_STRIDE constants.
- One sub-module: int_arb_prio_enc. Combinational fixed-priority encoder that takes the request vector and returns a valid flag plus the index.

Test Plan:
- reset; mask=4'b0100; pulse irq[2] → int_req=1 two cycles later, int_id=2, inter_addr=0x108. int_ack → pending[2]=0, busy=1.
- mask=4'hF; irq[1] and irq[3] rise in the same cycle → id 1 first (0x104). After ack, then done → id 3 (0x10C).
- mask=0; pulse irq[0] → pending=4'b0001, no int_req. Write mask=1 → int_req two cycles after mask_we.
- In SERVICE, pulse irq[0] → int_req stays 0 until int_done. Request appears 1 cycle after done.
- reset asserted while in REQ → next cycle int_req=0, pending=0, busy=0, inter_addr=0.
- With INT_ARB_OVF_TRAP_EN: mask=0; ovf and irq[0] rise together → int_id=4, inter_addr=0x110.
